// File: rtl/frame_renderer_if.sv
// frame_renderer_if: game-side bus into the renderer and the pixel stream toward vga_adapter
interface frame_renderer_if;
    logic       frame_tick;
    logic [2:0] player_height;
    logic [7:0] obstacle_x;
    logic       dead;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic       overrun;
    modport master (
        output frame_tick, player_height, obstacle_x, dead,
        input  x, y, colour, plot, busy, done, overrun
    );
    modport slave (
        input  frame_tick, player_height, obstacle_x, dead,
        output x, y, colour, plot, busy, done, overrun
    );
endinterface

// File: rtl/frame_renderer.sv
// frame_renderer: erases last frame's sprites and draws new ones, one pixel per cycle (optional ground line under FRAME_RENDERER_GROUND_EN)
module frame_renderer #(
    parameter int PLAYER_X    = 20,
    parameter int GROUND_Y    = 100,
    parameter int HEIGHT_STEP = 6
) (
    input logic              clock_i,
    input logic              reset_i,
    frame_renderer_if.slave  fr_if
);
`ifdef FRAME_RENDERER_GROUND_EN
    typedef enum logic [2:0] {IDLE, ERASE_P, ERASE_O, GROUND, DRAW_P, DRAW_O, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ERASE_P, ERASE_O, DRAW_P, DRAW_O, DONE} state_t;
`endif
    localparam logic [8:0] PX     = 9'(PLAYER_X);
    localparam logic [6:0] PTOP0  = 7'(GROUND_Y - 8);
    localparam logic [6:0] OTOP   = 7'(GROUND_Y - 12);
    localparam logic [6:0] GY     = 7'(GROUND_Y);
    localparam logic [6:0] HS     = 7'(HEIGHT_STEP);
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  cur_h_q, prev_h_q;
    logic [7:0]  cur_ox_q, prev_ox_q;
    logic        cur_dead_q, prev_valid_q;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic [2:0]  col_q;
    logic        plot_q, busy_q, done_q, overrun_q;
    logic [8:0]  px9;
    logic [6:0]  px_y, prev_top, cur_top;
    logic [2:0]  px_c;
    logic        px_en;
    assign prev_top = PTOP0 - {4'd0, prev_h_q} * HS;
    assign cur_top  = PTOP0 - {4'd0, cur_h_q} * HS;
    // next state and pixel counter; every drawing state ends on its last pixel index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        case (state_q)
            IDLE: begin
                cnt_d   = 8'd0;
                state_d = fr_if.frame_tick ? ERASE_P : IDLE;
            end
            ERASE_P: if (cnt_q == 8'd63) begin
                cnt_d   = 8'd0;
                state_d = ERASE_O;
            end
            ERASE_O: if (cnt_q == 8'd47) begin
                cnt_d   = 8'd0;
`ifdef FRAME_RENDERER_GROUND_EN
                state_d = GROUND;
`else
                state_d = DRAW_P;
`endif
            end
`ifdef FRAME_RENDERER_GROUND_EN
            GROUND: if (cnt_q == 8'd159) begin
                cnt_d   = 8'd0;
                state_d = DRAW_P;
            end
`endif
            DRAW_P: if (cnt_q == 8'd63) begin
                cnt_d   = 8'd0;
                state_d = DRAW_O;
            end
            DRAW_O: if (cnt_q == 8'd47) begin
                cnt_d   = 8'd0;
                state_d = DONE;
            end
            DONE: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end
    // pixel for the upcoming cycle, derived from the next state so outputs register with one-cycle latency
    always_comb begin
        px9   = {1'b0, x_q};
        px_y  = y_q;
        px_c  = col_q;
        px_en = 1'b0;
        case (state_d)
            ERASE_P: begin
                px9   = PX + 9'(cnt_d[2:0]);
                px_y  = prev_top + 7'(cnt_d[5:3]);
                px_c  = 3'b000;
                px_en = prev_valid_q;
            end
            ERASE_O: begin
                px9   = {1'b0, prev_ox_q} + 9'(cnt_d[1:0]);
                px_y  = OTOP + 7'(cnt_d[5:2]);
                px_c  = 3'b000;
                px_en = prev_valid_q;
            end
`ifdef FRAME_RENDERER_GROUND_EN
            GROUND: begin
                px9   = {1'b0, cnt_d};
                px_y  = GY;
                px_c  = 3'b110;
                px_en = 1'b1;
            end
`endif
            DRAW_P: begin
                px9   = PX + 9'(cnt_d[2:0]);
                px_y  = cur_top + 7'(cnt_d[5:3]);
                px_c  = cur_dead_q ? 3'b100 : 3'b010;
                px_en = 1'b1;
            end
            DRAW_O: begin
                px9   = {1'b0, cur_ox_q} + 9'(cnt_d[1:0]);
                px_y  = OTOP + 7'(cnt_d[5:2]);
                px_c  = 3'b111;
                px_en = 1'b1;
            end
            default: px_en = 1'b0;
        endcase
    end
    // state, counter and registered pixel outputs
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            x_q     <= 8'd0;
            y_q     <= 7'd0;
            col_q   <= 3'd0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= px9[7:0];
            y_q     <= px_y;
            col_q   <= px_c;
            plot_q  <= px_en && (px9 < 9'd160);
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == DONE;
        end
    end
    // tick snapshot, end-of-frame copy into prev_* and sticky overrun on dropped ticks
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cur_h_q      <= 3'd0;
            cur_ox_q     <= 8'd0;
            cur_dead_q   <= 1'b0;
            prev_h_q     <= 3'd0;
            prev_ox_q    <= 8'd0;
            prev_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && fr_if.frame_tick) begin
                cur_h_q    <= fr_if.player_height;
                cur_ox_q   <= fr_if.obstacle_x;
                cur_dead_q <= fr_if.dead;
            end
            if (state_q == DONE) begin
                prev_h_q     <= cur_h_q;
                prev_ox_q    <= cur_ox_q;
                prev_valid_q <= 1'b1;
            end
            overrun_q <= overrun_q | (fr_if.frame_tick && state_q != IDLE);
        end
    end
    assign fr_if.x       = x_q;
    assign fr_if.y       = y_q;
    assign fr_if.colour  = col_q;
    assign fr_if.plot    = plot_q;
    assign fr_if.busy    = busy_q;
    assign fr_if.done    = done_q;
    assign fr_if.overrun = overrun_q;
endmodule
